native_mem_copier: RTL

- Bus initiator on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Copies a block of 32-bit words from a source region to a destination region, or fills a region with a constant. This is the hardware assist for loading a boot image from ROM and clearing RAM before CPU reset release.
- Sits in front of the same memory responder the CPU uses, muxed ahead of the core while the CPU is held in reset.

---
 rtl/native_mem_copier.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/native_mem_copier.sv
// rtl/native_mem_copier.sv - picorv32 native-bus initiator that copies or fills blocks of 32-bit words.
module native_mem_copier #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fill_mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t           state_q;
    logic [31:0]      src_q, dst_q, data_q, addr_q, wdata_q, tmo_q;
    logic [CNT_W-1:0] count_q, words_q, words_d;
    logic [3:0]       wstrb_q;
    logic             fill_q, busy_q, done_q, error_q, valid_q;
    logic             xfer, tmo_hit;

    assign xfer    = valid_q && mem_ready;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && valid_q && !mem_ready && (tmo_q == TMO_LAST);
    assign words_d = words_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            count_q <= '0;
            words_q <= '0;
            wstrb_q <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= {src_addr[31:2], 2'b00};
                        dst_q   <= {dst_addr[31:2], 2'b00};
                        data_q  <= fill_value;
                        count_q <= word_count;
                        fill_q  <= fill_mode;
                        words_q <= '0;
                        error_q <= 1'b0;
                        tmo_q   <= '0;
                        if (word_count == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            // First request goes out straight from IDLE; no gap is needed here.
                            busy_q  <= 1'b1;
                            valid_q <= 1'b1;
                            wdata_q <= fill_value;
                            if (fill_mode) begin
                                state_q <= WR;
                                addr_q  <= {dst_addr[31:2], 2'b00};
                                wstrb_q <= 4'hF;
                            end else begin
                                state_q <= RD;
                                addr_q  <= {src_addr[31:2], 2'b00};
                                wstrb_q <= 4'h0;
                            end
                        end
                    end
                end
                RD, WR: begin
                    if (!valid_q) begin
                        // Gap cycle is over: launch the next request with fresh bus fields.
                        valid_q <= 1'b1;
                        tmo_q   <= '0;
                        addr_q  <= (state_q == RD) ? src_q : dst_q;
                        wdata_q <= data_q;
                        wstrb_q <= (state_q == RD) ? 4'h0 : 4'hF;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                        if (state_q == RD) begin
                            data_q  <= mem_rdata;
                            src_q   <= src_q + 32'd4;
                            state_q <= WR;
                        end else begin
                            dst_q   <= dst_q + 32'd4;
                            words_q <= words_d;
                            if (words_d == count_q) begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= fill_q ? WR : RD;
                            end
                        end
                    end else if (tmo_hit) begin
                        valid_q <= 1'b0;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_q;
    assign mem_valid  = valid_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
endmodule
